// File: rtl/line_buf_ctrl.sv
// Sequencer for the two-FIFO line buffer feeding the 3x3 window matrix.
// Tracks frame geometry from vs/de, drives FIFO enables and flags windows.
module line_buf_ctrl #(
    parameter int IMG_WIDTH  = 1920,
    parameter int IMG_HEIGHT = 1080,
    parameter int PIPE_DLY   = 2
) (
    input  logic        video_clk,
    input  logic        rst_n,
    input  logic        i_vs,
    input  logic        i_de,
    output logic        o_fifo_rst,
    output logic        o_fifo1_wr_en,
    output logic        o_fifo2_wr_en,
    output logic        o_fifo_rd_en,
    output logic        o_win_valid,
    output logic [11:0] o_win_x,
    output logic [11:0] o_win_y,
    output logic        o_frame_done,
    output logic        o_frame_err
);

    localparam logic [11:0] X_LAST = 12'(IMG_WIDTH - 1);
    localparam logic [11:0] Y_LAST = 12'(IMG_HEIGHT - 1);

    typedef enum logic [1:0] {
        IDLE,
        FLUSH,
        ACTIVE,
        DONE
    } state_t;

    state_t      state;
    logic        vs_d;
    logic        rise;
    logic        flush_cnt;
    logic [11:0] x;
    logic [11:0] y;
    logic        active;
    logic        last_px;
    logic        accept;
    logic        hit;
    logic        err_now;

    logic        vld_p [PIPE_DLY];
    logic [11:0] x_p   [PIPE_DLY];
    logic [11:0] y_p   [PIPE_DLY];

    // Sampled through reset so a vs level held across reset is not taken as a new frame.
    always_ff @(posedge video_clk) begin
        vs_d <= i_vs;
    end

    assign rise    = i_vs & ~vs_d;
    assign active  = (state == ACTIVE);
    assign last_px = (x == X_LAST) && (y == Y_LAST);

    // A new vs drops the coincident pixel unless it is the frame's final pixel.
    assign accept  = active & i_de & (~rise | last_px);
    assign hit     = accept & (x >= 12'd2) & (y >= 12'd2);

    assign err_now = (active & rise & ~(i_de & last_px))
                   | (active & ~rise & ~i_de & (x != 12'd0))
                   | ((state == DONE) & i_de);

    assign o_fifo1_wr_en = accept & (y < Y_LAST);
    assign o_fifo_rd_en  = accept & (y != 12'd0);

    always_ff @(posedge video_clk) begin
        if (!rst_n) begin
            o_fifo2_wr_en <= 1'b0;
        end else begin
            o_fifo2_wr_en <= o_fifo_rd_en;
        end
    end

    always_ff @(posedge video_clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            flush_cnt    <= 1'b0;
            x            <= 12'd0;
            y            <= 12'd0;
            o_fifo_rst   <= 1'b0;
            o_frame_done <= 1'b0;
            o_frame_err  <= 1'b0;
        end else begin
            o_frame_done <= accept & last_px;
            o_frame_err  <= err_now;
            case (state)
                IDLE: begin
                    if (rise) begin
                        state      <= FLUSH;
                        flush_cnt  <= 1'b0;
                        o_fifo_rst <= 1'b1;
                    end
                end
                FLUSH: begin
                    if (rise) begin
                        flush_cnt <= 1'b0;
                    end else if (flush_cnt) begin
                        state      <= ACTIVE;
                        o_fifo_rst <= 1'b0;
                        x          <= 12'd0;
                        y          <= 12'd0;
                    end else begin
                        flush_cnt <= 1'b1;
                    end
                end
                ACTIVE: begin
                    if (rise) begin
                        state      <= FLUSH;
                        flush_cnt  <= 1'b0;
                        o_fifo_rst <= 1'b1;
                        x          <= 12'd0;
                        y          <= 12'd0;
                    end else if (err_now) begin
                        state <= IDLE;
                        x     <= 12'd0;
                        y     <= 12'd0;
                    end else if (accept) begin
                        if (last_px) begin
                            state <= DONE;
                            x     <= 12'd0;
                            y     <= 12'd0;
                        end else if (x == X_LAST) begin
                            x <= 12'd0;
                            y <= y + 12'd1;
                        end else begin
                            x <= x + 12'd1;
                        end
                    end
                end
                DONE: begin
                    if (rise) begin
                        state      <= FLUSH;
                        flush_cnt  <= 1'b0;
                        o_fifo_rst <= 1'b1;
                    end else if (i_de) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Window tag pipeline, flushed on any geometry error so a broken frame emits nothing more.
    always_ff @(posedge video_clk) begin
        if (!rst_n || err_now) begin
            for (int k = 0; k < PIPE_DLY; k++) begin
                vld_p[k] <= 1'b0;
                x_p[k]   <= 12'd0;
                y_p[k]   <= 12'd0;
            end
        end else begin
            vld_p[0] <= hit;
            x_p[0]   <= hit ? x - 12'd1 : 12'd0;
            y_p[0]   <= hit ? y - 12'd1 : 12'd0;
            for (int k = 1; k < PIPE_DLY; k++) begin
                vld_p[k] <= vld_p[k-1];
                x_p[k]   <= x_p[k-1];
                y_p[k]   <= y_p[k-1];
            end
        end
    end

    assign o_win_valid = vld_p[PIPE_DLY-1];
    assign o_win_x     = x_p[PIPE_DLY-1];
    assign o_win_y     = y_p[PIPE_DLY-1];

endmodule

// File: tb/tb_line_buf_ctrl.sv
// Randomised frame-timing bench for line_buf_ctrl against a frame-level reference model.
module tb_line_buf_ctrl;

    localparam int W  = 8;
    localparam int H  = 4;
    localparam int PD = 2;

    logic        video_clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_vs = 1'b0;
    logic        i_de = 1'b0;
    logic        o_fifo_rst;
    logic        o_fifo1_wr_en;
    logic        o_fifo2_wr_en;
    logic        o_fifo_rd_en;
    logic        o_win_valid;
    logic [11:0] o_win_x;
    logic [11:0] o_win_y;
    logic        o_frame_done;
    logic        o_frame_err;

    line_buf_ctrl #(
        .IMG_WIDTH (W),
        .IMG_HEIGHT(H),
        .PIPE_DLY  (PD)
    ) dut (
        .video_clk    (video_clk),
        .rst_n        (rst_n),
        .i_vs         (i_vs),
        .i_de         (i_de),
        .o_fifo_rst   (o_fifo_rst),
        .o_fifo1_wr_en(o_fifo1_wr_en),
        .o_fifo2_wr_en(o_fifo2_wr_en),
        .o_fifo_rd_en (o_fifo_rd_en),
        .o_win_valid  (o_win_valid),
        .o_win_x      (o_win_x),
        .o_win_y      (o_win_y),
        .o_frame_done (o_frame_done),
        .o_frame_err  (o_frame_err)
    );

    always #5 video_clk = ~video_clk;

    int n_chk = 0;
    int n_bad = 0;
    int cyc   = 0;

    typedef struct {
        int due;
        int wx;
        int wy;
    } win_t;
    win_t wq[$];

    // Reference: a frame is a run of W*H accepted pixels; position is derived from the count.
    bit m_vs_d;
    int m_flush;
    bit m_frame;
    bit m_after;
    int m_pix;
    bit m_done_q;
    bit m_err_q;
    bit m_rd_d;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_vs_d   = i_vs;
        m_flush  = 0;
        m_frame  = 0;
        m_after  = 0;
        m_pix    = 0;
        m_done_q = 0;
        m_err_q  = 0;
        m_rd_d   = 0;
        wq.delete();
    endtask

    task automatic model_eval();
        bit rise, last, acc, wr1, rd, err, ev;
        int px, py;
        win_t w;
        rise = i_vs && !m_vs_d;
        px   = m_pix % W;
        py   = m_pix / W;
        last = m_frame && (m_pix == W * H - 1);
        acc  = m_frame && i_de && (!rise || last);
        wr1  = acc && (py < H - 1);
        rd   = acc && (py > 0);

        check_val("fifo_rst", int'(o_fifo_rst), int'(m_flush > 0));
        check_val("fifo1_wr", int'(o_fifo1_wr_en), int'(wr1));
        check_val("rd_en", int'(o_fifo_rd_en), int'(rd));
        check_val("fifo2_wr", int'(o_fifo2_wr_en), int'(m_rd_d));
        check_val("frame_done", int'(o_frame_done), int'(m_done_q));
        check_val("frame_err", int'(o_frame_err), int'(m_err_q));
        ev = (wq.size() > 0) && (wq[0].due == cyc);
        check_val("win_valid", int'(o_win_valid), int'(ev));
        if (ev) begin
            check_val("win_x", int'(o_win_x), wq[0].wx);
            check_val("win_y", int'(o_win_y), wq[0].wy);
            wq.delete(0);
        end

        err = 0;
        if (m_frame && rise && !(i_de && last)) err = 1;
        if (m_frame && !rise && !i_de && px != 0) err = 1;
        if (m_after && i_de) err = 1;

        m_done_q = acc && last;
        m_err_q  = err;
        m_rd_d   = rd;
        if (err) begin
            wq.delete();
        end else if (acc && px >= 2 && py >= 2) begin
            w.due = cyc + PD;
            w.wx  = px - 1;
            w.wy  = py - 1;
            wq.push_back(w);
        end
        if (acc) m_pix++;

        if (rise) begin
            m_flush = 2;
            m_frame = 0;
            m_after = 0;
        end else if (m_flush > 0) begin
            m_flush--;
            if (m_flush == 0) begin
                m_frame = 1;
                m_pix   = 0;
            end
        end else if (err) begin
            m_frame = 0;
            m_after = 0;
        end else if (acc && last) begin
            m_frame = 0;
            m_after = 1;
        end
        m_vs_d = i_vs;
    endtask

    task automatic step(input bit vs, input bit de, input bit rst = 1'b0);
        @(negedge video_clk);
        i_vs  = vs;
        i_de  = de;
        rst_n = !rst;
        #1;
        if (rst) model_reset();
        else model_eval();
        cyc++;
    endtask

    // lead: 0 = vs already started this frame, 1 = low then high, 2 = high at once.
    task automatic frame(input int lead, input int cut_y, input int cut_x,
                         input int vs_y, input int vs_x, input int rst_y, input int rst_x,
                         input bit vs_last, input bit extra_de);
        if (lead == 1) step(0, 0);
        if (lead != 0) repeat ($urandom_range(1, 3)) step(1, 0);
        repeat ($urandom_range(3, 5)) step(0, 0);
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                if (y == rst_y && x == rst_x) begin
                    step(0, 1, 1);
                    step(0, 0, 1);
                    repeat ($urandom_range(2, 5)) step(0, 1);
                    return;
                end
                if (y == cut_y && x == cut_x) begin
                    repeat ($urandom_range(1, 4)) step(0, 0);
                    return;
                end
                if (y == vs_y && x == vs_x) begin
                    step(1, 1);
                    return;
                end
                if (vs_last && y == H - 1 && x == W - 1) step(1, 1);
                else step(0, 1);
            end
            if (y == vs_y && vs_x == W) begin
                step(1, 0);
                return;
            end
            if (y < H - 1) repeat ($urandom_range(1, 4)) step(0, 0);
        end
        if (extra_de) begin
            repeat ($urandom_range(1, 3)) step(0, 0);
            step(0, 1);
            step(0, 0);
        end
    endtask

    initial begin
        int kind, cy, cx, vy, vx, ry, rx, lead;
        bit vl, ex;
        repeat (3) step(0, 0, 1);
        step(0, 0);

        frame(1, -1, 0, -1, 0, -1, 0, 1'b0, 1'b0);
        repeat (3) step(0, 0);
        frame(1, -1, 0, -1, 0, -1, 0, 1'b0, 1'b0);
        frame(2, -1, 0, -1, 0, -1, 0, 1'b0, 1'b0);
        repeat (3) step(0, 0);
        frame(1, 1, 5, -1, 0, -1, 0, 1'b0, 1'b0);
        repeat (3) step(0, 1);
        frame(1, -1, 0, 2, 3, -1, 0, 1'b0, 1'b0);
        frame(0, -1, 0, -1, 0, -1, 0, 1'b0, 1'b0);
        frame(1, -1, 0, -1, 0, 2, 4, 1'b0, 1'b0);
        frame(1, -1, 0, -1, 0, -1, 0, 1'b0, 1'b1);
        frame(1, -1, 0, -1, 0, -1, 0, 1'b1, 1'b0);
        frame(0, -1, 0, -1, 0, -1, 0, 1'b0, 1'b0);

        for (int i = 0; i < 150; i++) begin
            kind = $urandom_range(0, 7);
            cy = -1; cx = 0; vy = -1; vx = 0; ry = -1; rx = 0;
            vl = 1'b0; ex = 1'b0;
            lead = i_vs ? 0 : $urandom_range(1, 2);
            case (kind)
                1: begin cy = $urandom_range(0, H - 1); cx = $urandom_range(1, W - 1); end
                2: begin vy = $urandom_range(0, H - 1); vx = $urandom_range(0, W); end
                3: begin ry = $urandom_range(0, H - 1); rx = $urandom_range(0, W - 1); end
                4: vl = 1'b1;
                5: ex = 1'b1;
                default: ;
            endcase
            frame(lead, cy, cx, vy, vx, ry, rx, vl, ex);
            if ($urandom_range(0, 2) == 0)
                repeat ($urandom_range(1, 6)) step(0, 1'($urandom_range(0, 1)));
        end
        repeat (6) step(0, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
